// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side master for an 8-bit x 2048 simple-dual-port block RAM that has a
// 2-cycle read latency (RDEN plus output register). On START it reads LEN
// bytes upward from START_ADDR and presents them, in address order, on a
// valid/ready byte stream. A small skid FIFO absorbs reads that are already
// in flight, so the consumer may stall on any cycle.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset (also feeds BRAM)
//   START             one-cycle request pulse, sampled only while idle
//   START_ADDR, LEN   first address and byte count (0..2048)
//   BUSY              high from the accepted START until DONE
//   DONE              one-cycle pulse after the last byte is accepted
//   ERR               one-cycle pulse when a request is rejected
//   RDADDR, RDEN      BRAM read address / enable (one RDEN pulse per byte)
//   REGCE             BRAM output register enable, low only during reset
//   DO                BRAM read data
//   M_DATA, M_VALID   stream data / valid, taken from the FIFO head
//   M_READY           stream ready; a byte moves when M_VALID && M_READY
//
// Configuration macro
//   BRAM_READER_WRAP_EN  defined: addresses wrap 2047 -> 0 and every request
//                        is accepted (ERR is never raised).
//                        undefined: a request with START_ADDR+LEN > 2048 is
//                        rejected with an ERR pulse.
// -----------------------------------------------------------------------------

module bram_stream_reader_chk #(
    parameter int FIFO_D = 4,
    parameter int CNT_W  = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);
    // A capture into a full FIFO without a simultaneous pop would drop a byte;
    // the credit rule must make this unreachable.
    property p_no_overflow;
        @(posedge clk) disable iff (rst)
            !(push && !pop && (count == CNT_W'(FIFO_D)));
    endproperty

    a_no_overflow: assert property (p_no_overflow);
endmodule

module bram_stream_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] RDADDR,
    output logic              RDEN,
    output logic              REGCE,
    input  logic [DATA_W-1:0] DO,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY
);
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int PTR_W = $clog2(FIFO_D);

    localparam logic [ADDR_W:0]   LEN_ZERO   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] MEM_SIZE   = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_D - 1);
    localparam logic [RD_LAT-1:0] VLD_ZERO   = {RD_LAT{1'b0}};
    localparam logic [7:0]        CREDIT_MAX = 8'(FIFO_D);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } state_t;

    function automatic logic [7:0] count_ones(input logic [RD_LAT-1:0] bits);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + {7'd0, bits[i]};
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
    endfunction

    state_t              state_r, state_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                err_r, err_nxt_s;
    logic                rden_r, rden_nxt_s;
    logic [ADDR_W-1:0]   rdaddr_r, rdaddr_nxt_s;
    logic [ADDR_W:0]     remaining_r, remaining_nxt_s;
    logic [RD_LAT-1:0]   vld_sr_r;

    logic [DATA_W-1:0]   fifo_mem_r [FIFO_D];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r, count_nxt_s;

    logic                push_s, pop_s;
    logic                issue_ok_s, req_bad_s, drain_done_s;
    logic [7:0]          outstanding_s;
    logic [ADDR_W+1:0]   req_end_s;

    assign push_s  = vld_sr_r[RD_LAT-1];
    assign M_VALID = (count_r != CNT_ZERO);
    assign pop_s   = M_VALID & M_READY;
    assign M_DATA  = fifo_mem_r[rd_ptr_r];

    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ERR    = err_r;
    assign RDEN   = rden_r;
    assign RDADDR = rdaddr_r;
    assign REGCE  = ~RST;

    // Bytes that will be held or in flight after this edge if no new read is
    // issued now; a new read is allowed only if it still fits in the FIFO.
    assign outstanding_s = 8'(count_r) + {7'd0, rden_r} + count_ones(vld_sr_r);
    assign issue_ok_s    = (outstanding_s < (CREDIT_MAX + {7'd0, pop_s}));

    assign req_end_s = {2'b00, START_ADDR} + {1'b0, LEN};
`ifdef BRAM_READER_WRAP_EN
    assign req_bad_s = 1'b0;
`else
    assign req_bad_s = (req_end_s > MEM_SIZE);
`endif

    // Transfer finishes once nothing is in flight and the FIFO empties this cycle.
    assign drain_done_s = !rden_r && (vld_sr_r == VLD_ZERO) && (count_nxt_s == CNT_ZERO);

    // FIFO occupancy for the next cycle; push and pop together leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next-state and next-output logic of the request/issue/drain controller.
    always_comb begin
        state_nxt_s     = state_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        rden_nxt_s      = 1'b0;
        rdaddr_nxt_s    = rdaddr_r;
        remaining_nxt_s = remaining_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    if (LEN == LEN_ZERO) begin
                        done_nxt_s = 1'b1;
                    end else if (req_bad_s) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        // The first read goes out in the cycle after START.
                        state_nxt_s     = ISSUE;
                        busy_nxt_s      = 1'b1;
                        rden_nxt_s      = 1'b1;
                        rdaddr_nxt_s    = START_ADDR;
                        remaining_nxt_s = LEN - LEN_ONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (remaining_r == LEN_ZERO) begin
                    state_nxt_s = DRAIN;
                end else if (issue_ok_s) begin
                    rden_nxt_s      = 1'b1;
                    rdaddr_nxt_s    = rdaddr_r + ADDR_ONE;
                    remaining_nxt_s = remaining_r - LEN_ONE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Controller state, BRAM request outputs and in-flight read tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rden_r      <= 1'b0;
            rdaddr_r    <= ADDR_ZERO;
            remaining_r <= LEN_ZERO;
            vld_sr_r    <= VLD_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            rden_r      <= rden_nxt_s;
            rdaddr_r    <= rdaddr_nxt_s;
            remaining_r <= remaining_nxt_s;
            // The oldest bit marks a cycle in which DO carries a requested byte.
            vld_sr_r    <= {vld_sr_r[RD_LAT-2:0], rden_r};
        end
    end

    // Skid FIFO: captures DO when the matching read emerges, drains on handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= DO;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    bram_stream_reader_chk #(
        .FIFO_D (FIFO_D),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule
